// File: rtl/lcd_text_ctrl.sv
// Character LCD controller: power-up wait, init sequence, then continuous line-by-line refresh from a writable buffer.
// Latency: a buffer write is visible on the next clk edge and shows on the panel at that character's next SETUP start.
// Backpressure: none; writes are always accepted, and the LCD bus is paced only by CLK_DIV (3*CLK_DIV cycles per transaction).
module lcd_text_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int LINES      = 4,
    parameter int COLS       = 16,
    parameter int POWER_WAIT = 1000,
    parameter int CLEAR_WAIT = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       frame_done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_rst,
    output logic [7:0] lcd_db
);

    localparam int DEPTH = LINES * COLS;
    localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WMAX  = (POWER_WAIT > CLEAR_WAIT) ? POWER_WAIT : CLEAR_WAIT;
    localparam int WW    = (WMAX > 1) ? $clog2(WMAX) : 1;
    localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {PWR_WAIT, INIT, CLR_WAIT, LINE_ADDR, CHAR} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_HIGH, PH_HOLD} phase_t;

    state_t          state, state_n;
    phase_t          phase, phase_n;
    logic [PW-1:0]   phase_cnt, pcnt_n;
    logic [WW-1:0]   wait_cnt, wait_n;
    logic [1:0]      init_idx, init_n;
    logic [LW-1:0]   line, line_n;
    logic [CW-1:0]   col, col_n;
    logic            busy_n, done_n;
    logic            start, start_rs;
    logic [7:0]      start_db;
    logic            xact_end;
    logic [5:0]      rd_addr;
    logic [7:0]      char_dat;

    // Buffer is a fixed 64 entries so any 6-bit address indexes safely; only DEPTH entries are writable or read.
    logic [7:0]      buf_mem [64];

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h30;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] line_base(input logic [1:0] l);
        case (l)
            2'd0:    line_base = 8'h80;
            2'd1:    line_base = 8'h90;
            2'd2:    line_base = 8'h88;
            default: line_base = 8'h98;
        endcase
    endfunction

    assign lcd_rw   = 1'b0;
    assign lcd_rst  = rst;
    assign xact_end = (phase == PH_HOLD) && (phase_cnt == PW'(CLK_DIV - 1));

    // Next character to send: col+1 while walking a line, col 0 right after the line address command.
    assign rd_addr  = (state == CHAR) ? 6'(32'(line) * COLS + 32'(col) + 1)
                                      : 6'(32'(line) * COLS);
    assign char_dat = buf_mem[rd_addr];

    // Host writes; out-of-range addresses are dropped, reset restores all spaces.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) buf_mem[i] <= 8'h20;
        end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
            buf_mem[wr_addr] <= wr_data;
        end
    end

    // Next-state: sequencing of waits, transactions and the line/column walk.
    always_comb begin
        state_n  = state;
        phase_n  = phase;
        pcnt_n   = phase_cnt;
        wait_n   = wait_cnt;
        init_n   = init_idx;
        line_n   = line;
        col_n    = col;
        busy_n   = busy;
        done_n   = 1'b0;
        start    = 1'b0;
        start_rs = 1'b0;
        start_db = 8'h00;
        case (state)
            PWR_WAIT: begin
                if (wait_cnt == WW'(POWER_WAIT - 1)) begin
                    state_n  = INIT;
                    wait_n   = '0;
                    init_n   = 2'd0;
                    start    = 1'b1;
                    start_db = init_cmd(2'd0);
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            CLR_WAIT: begin
                if (wait_cnt == WW'(CLEAR_WAIT - 1)) begin
                    state_n  = LINE_ADDR;
                    wait_n   = '0;
                    line_n   = '0;
                    busy_n   = 1'b0;
                    start    = 1'b1;
                    start_db = line_base(2'd0);
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            default: begin
                if (!xact_end) begin
                    if (phase_cnt == PW'(CLK_DIV - 1)) begin
                        phase_n = phase_t'(phase + 2'd1);
                        pcnt_n  = '0;
                    end else begin
                        pcnt_n = phase_cnt + 1'b1;
                    end
                end else begin
                    case (state)
                        INIT: begin
                            if (init_idx == 2'd3) begin
                                state_n = CLR_WAIT;
                                wait_n  = '0;
                            end else begin
                                init_n   = init_idx + 2'd1;
                                start    = 1'b1;
                                start_db = init_cmd(init_idx + 2'd1);
                            end
                        end
                        LINE_ADDR: begin
                            state_n  = CHAR;
                            col_n    = '0;
                            start    = 1'b1;
                            start_rs = 1'b1;
                            start_db = char_dat;
                        end
                        CHAR: begin
                            start = 1'b1;
                            if (col != CW'(COLS - 1)) begin
                                col_n    = col + 1'b1;
                                start_rs = 1'b1;
                                start_db = char_dat;
                            end else if (line != LW'(LINES - 1)) begin
                                state_n  = LINE_ADDR;
                                line_n   = line + 1'b1;
                                start_db = line_base(2'(line) + 2'd1);
                            end else begin
                                state_n  = LINE_ADDR;
                                line_n   = '0;
                                done_n   = 1'b1;
                                start_db = line_base(2'd0);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        if (start) begin
            phase_n = PH_SETUP;
            pcnt_n  = '0;
        end
    end

    // State and registered LCD pins; rs/db only move when a new transaction starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PWR_WAIT;
            phase      <= PH_SETUP;
            phase_cnt  <= '0;
            wait_cnt   <= '0;
            init_idx   <= '0;
            line       <= '0;
            col        <= '0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
            lcd_en     <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_db     <= 8'h00;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            phase_cnt  <= pcnt_n;
            wait_cnt   <= wait_n;
            init_idx   <= init_n;
            line       <= line_n;
            col        <= col_n;
            busy       <= busy_n;
            frame_done <= done_n;
            lcd_en     <= (state_n == INIT || state_n == LINE_ADDR || state_n == CHAR)
                          && (phase_n == PH_HIGH);
            if (start) begin
                lcd_rs <= start_rs;
                lcd_db <= start_db;
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Bench for lcd_text_ctrl: scoreboard of expected LCD transactions plus timing checks.
// Cycle n = value sampled 1 time unit after the n-th rising edge following reset release.
// Small parameters: CLK_DIV=2, POWER_WAIT=10, CLEAR_WAIT=20, LINES=2, COLS=4.
module tb_lcd_text_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = 6'd0;
    logic [7:0] wr_data = 8'd0;
    logic       busy, frame_done, lcd_en, lcd_rs, lcd_rw, lcd_rst;
    logic [7:0] lcd_db;

    lcd_text_ctrl #(
        .CLK_DIV(2), .LINES(2), .COLS(4), .POWER_WAIT(10), .CLEAR_WAIT(20)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_rst(lcd_rst), .lcd_db(lcd_db)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [8:0] sb [$];
    logic [7:0] model [8];

    int         cyc = 0;
    int         rise_idx = 0;
    int         next_fd = 114;
    int         fd_cnt = 0;
    logic       prev_en = 1'b0;
    logic       prev_busy = 1'b1;
    logic       prev_fd = 1'b0;
    logic       cap_rs = 1'b0;
    logic [7:0] cap_db = 8'h00;
    logic [8:0] exp_x;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_x(input logic rs, input logic [7:0] db);
        sb.push_back({rs, db});
    endtask

    task automatic push_init();
        push_x(1'b0, 8'h30);
        push_x(1'b0, 8'h0C);
        push_x(1'b0, 8'h06);
        push_x(1'b0, 8'h01);
    endtask

    task automatic push_frame();
        push_x(1'b0, 8'h80);
        for (int c = 0; c < 4; c++) push_x(1'b1, model[c]);
        push_x(1'b0, 8'h90);
        for (int c = 0; c < 4; c++) push_x(1'b1, model[4 + c]);
    endtask

    // Caller is at a falling edge; the write is captured at the next rising edge.
    task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        if (a < 6'd8) model[a[2:0]] = d;
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (cyc < target) check("wait_timeout", cyc, target);
    endtask

    // Bus monitor: scoreboard pops on each enable rise, plus init spacing, hold stability, busy and frame timing.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            cyc       = 0;
            rise_idx  = 0;
            next_fd   = 114;
            prev_en   = 1'b0;
            prev_busy = 1'b1;
            prev_fd   = 1'b0;
        end else begin
            cyc++;
            if (lcd_en && !prev_en) begin
                if (rise_idx < 4) check("init_rise_cycle", cyc, 12 + 6 * rise_idx);
                rise_idx++;
                cap_rs = lcd_rs;
                cap_db = lcd_db;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(lcd_db), 32'hFFFF);
                end else begin
                    exp_x = sb.pop_front();
                    check("xact_rs", 32'(lcd_rs), 32'(exp_x[8]));
                    check("xact_db", 32'(lcd_db), 32'(exp_x[7:0]));
                end
            end
            if (!lcd_en && prev_en) begin
                check("hold_rs_stable", 32'(lcd_rs), 32'(cap_rs));
                check("hold_db_stable", 32'(lcd_db), 32'(cap_db));
            end
            if (prev_busy && !busy) check("busy_fall_cycle", cyc, 54);
            if (frame_done) begin
                check("frame_done_cycle", cyc, next_fd);
                check("frame_done_width", 32'(prev_fd), 32'd0);
                next_fd += 60;
                fd_cnt++;
            end
            prev_en   = lcd_en;
            prev_busy = busy;
            prev_fd   = frame_done;
        end
    end

    initial begin
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lcd_en", 32'(lcd_en), 32'd0);
        check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        check("rst_lcd_db", 32'(lcd_db), 32'h00);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_lcd_rst", 32'(lcd_rst), 32'd0);
        check("rst_lcd_rw", 32'(lcd_rw), 32'd0);

        for (int i = 0; i < 8; i++) model[i] = 8'h20;
        push_init();
        rst = 1'b1;

        // Writes during the power-up wait, then three frames of that content.
        @(negedge clk);
        bus_write(6'd0, 8'h5A);
        bus_write(6'd7, 8'h41);
        check("busy_in_pwr_wait", 32'(busy), 32'd1);
        push_frame();
        push_frame();
        push_frame();

        // Out-of-range write during the first frame must leave later frames unchanged.
        wait_cyc(70);
        bus_write(6'd8, 8'h77);

        // Write addr 1 on the very edge its SETUP samples it (frame 2, cycle 186).
        wait_cyc(185);
        bus_write(6'd1, 8'h42);
        push_frame();
        push_x(1'b0, 8'h80);

        // Reset during the HIGH phase of the next line-address command.
        wait_cyc(296);
        check("pre_rst_en_high", 32'(lcd_en), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_lcd_en", 32'(lcd_en), 32'd0);
        check("midrst_lcd_db", 32'(lcd_db), 32'h00);
        check("midrst_lcd_rs", 32'(lcd_rs), 32'd0);
        check("midrst_busy", 32'(busy), 32'd1);
        check("sb_drained_before_rst", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) model[i] = 8'h20;
        push_init();
        push_frame();
        rst = 1'b1;

        wait_cyc(11);
        check("restart_idle_en", 32'(lcd_en), 32'd0);
        check("restart_idle_busy", 32'(busy), 32'd1);

        wait_cyc(115);
        check("sb_drained_end", 32'(sb.size()), 32'd0);
        check("frame_done_count", 32'(fd_cnt), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
